// File: rtl/mul16_arb_seq.sv
// Two-requester arbiter that serialises 16x16 unsigned multiplies through a byte-wide
// external multiplier: four operand-byte writes, four product-byte reads, then a done pulse.
module mul16_arb_seq #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        busy,
    output logic [7:0]  mul_bus_in,
    output logic [1:0]  mul_wr_sel,
    output logic        mul_wr_en,
    output logic [1:0]  mul_rd_sel,
    output logic        mul_rd_en,
    input  logic [7:0]  mul_bus_out
);

    typedef enum logic [3:0] {
        IDLE, LD_AH, LD_AL, LD_BH, LD_BL,
        RD_C1, RD_C2, RD_C3, RD_C4, RD_LAST, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic        gid_q, gid_d;
    logic        last_q, last_d;
    logic        grant_vld, grant_id;
    logic [31:0] result_q;
    logic        done0_q, done1_q, busy_q;
    logic        wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [1:0]  wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [7:0]  bus_in_q, bus_in_d;

    // A tie goes to whoever was not served last; last_q resets to 1 so requester 0 wins first.
    always_comb begin
        grant_vld = (state_q == IDLE) && (req0 || req1) && !rst;
        if (req0 && req1) grant_id = RR_EN ? ~last_q : 1'b0;
        else              grant_id = req1;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gid_d   = gid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (grant_vld) begin
                state_d = LD_AH;
                a_d     = grant_id ? a1 : a0;
                b_d     = grant_id ? b1 : b0;
                gid_d   = grant_id;
                last_d  = grant_id;
            end
            LD_AH:   state_d = LD_AL;
            LD_AL:   state_d = LD_BH;
            LD_BH:   state_d = LD_BL;
            LD_BL:   state_d = RD_C1;
            RD_C1:   state_d = RD_C2;
            RD_C2:   state_d = RD_C3;
            RD_C3:   state_d = RD_C4;
            RD_C4:   state_d = RD_LAST;
            RD_LAST: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiplier strobes are decoded from the next state so they come out of flops.
    always_comb begin
        wr_en_d  = 1'b0;
        wr_sel_d = 2'd0;
        bus_in_d = 8'd0;
        rd_en_d  = 1'b0;
        rd_sel_d = 2'd0;
        case (state_d)
            LD_AH: begin wr_en_d = 1'b1; wr_sel_d = 2'd0; bus_in_d = a_d[15:8]; end
            LD_AL: begin wr_en_d = 1'b1; wr_sel_d = 2'd1; bus_in_d = a_d[7:0];  end
            LD_BH: begin wr_en_d = 1'b1; wr_sel_d = 2'd2; bus_in_d = b_d[15:8]; end
            LD_BL: begin wr_en_d = 1'b1; wr_sel_d = 2'd3; bus_in_d = b_d[7:0];  end
            RD_C1: begin rd_en_d = 1'b1; rd_sel_d = 2'd0; end
            RD_C2: begin rd_en_d = 1'b1; rd_sel_d = 2'd1; end
            RD_C3: begin rd_en_d = 1'b1; rd_sel_d = 2'd2; end
            RD_C4: begin rd_en_d = 1'b1; rd_sel_d = 2'd3; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gid_q    <= 1'b0;
            last_q   <= 1'b1;
            result_q <= 32'd0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            wr_en_q  <= 1'b0;
            wr_sel_q <= 2'd0;
            bus_in_q <= 8'd0;
            rd_en_q  <= 1'b0;
            rd_sel_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            gid_q    <= gid_d;
            last_q   <= last_d;
            done0_q  <= (state_d == DONE) && !gid_d;
            done1_q  <= (state_d == DONE) && gid_d;
            busy_q   <= (state_d != IDLE);
            wr_en_q  <= wr_en_d;
            wr_sel_q <= wr_sel_d;
            bus_in_q <= bus_in_d;
            rd_en_q  <= rd_en_d;
            rd_sel_q <= rd_sel_d;
            // Each product byte appears on mul_bus_out one state after its read strobe.
            case (state_q)
                RD_C2:   result_q[31:24] <= mul_bus_out;
                RD_C3:   result_q[23:16] <= mul_bus_out;
                RD_C4:   result_q[15:8]  <= mul_bus_out;
                RD_LAST: result_q[7:0]   <= mul_bus_out;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign ack0       = grant_vld && !grant_id;
    assign ack1       = grant_vld && grant_id;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign mul_bus_in = bus_in_q;
    assign mul_wr_sel = wr_sel_q;
    assign mul_wr_en  = wr_en_q;
    assign mul_rd_sel = rd_sel_q;
    assign mul_rd_en  = rd_en_q;

endmodule

// File: tb/tb_mul16_arb_seq.sv
// Bench for mul16_arb_seq: behavioural byte-wide multiplier, ack/done scoreboard,
// a table of products and hand sequences for arbitration, reset and busy corners.
module tb_mul16_arb_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        ack0, ack1, done0, done1, busy;
    logic [31:0] result;
    logic [7:0]  mul_bus_in, mul_bus_out;
    logic [1:0]  mul_wr_sel, mul_rd_sel;
    logic        mul_wr_en, mul_rd_en;

    logic        fp_ack0, fp_ack1, fp_done0, fp_done1, fp_busy;
    logic [31:0] fp_result;
    logic [7:0]  fp_bus_in;
    logic [7:0]  fp_bus_out = 8'h00;
    logic [1:0]  fp_wr_sel, fp_rd_sel;
    logic        fp_wr_en, fp_rd_en;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    mul16_arb_seq #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result(result), .busy(busy),
        .mul_bus_in(mul_bus_in), .mul_wr_sel(mul_wr_sel), .mul_wr_en(mul_wr_en),
        .mul_rd_sel(mul_rd_sel), .mul_rd_en(mul_rd_en), .mul_bus_out(mul_bus_out)
    );

    mul16_arb_seq #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(fp_ack0), .ack1(fp_ack1), .done0(fp_done0), .done1(fp_done1),
        .result(fp_result), .busy(fp_busy),
        .mul_bus_in(fp_bus_in), .mul_wr_sel(fp_wr_sel), .mul_wr_en(fp_wr_en),
        .mul_rd_sel(fp_rd_sel), .mul_rd_en(fp_rd_en), .mul_bus_out(fp_bus_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: byte operand registers, combinational product, registered read byte.
    logic [7:0]  m_ah = 8'h00, m_al = 8'h00, m_bh = 8'h00, m_bl = 8'h00;
    logic [31:0] m_prod;
    assign m_prod = 32'({m_ah, m_al}) * 32'({m_bh, m_bl});

    always @(posedge clk) begin
        if (mul_wr_en) begin
            case (mul_wr_sel)
                2'd0: m_ah <= mul_bus_in;
                2'd1: m_al <= mul_bus_in;
                2'd2: m_bh <= mul_bus_in;
                default: m_bl <= mul_bus_in;
            endcase
        end
        if (mul_rd_en) begin
            case (mul_rd_sel)
                2'd0: mul_bus_out <= m_prod[31:24];
                2'd1: mul_bus_out <= m_prod[23:16];
                2'd2: mul_bus_out <= m_prod[15:8];
                default: mul_bus_out <= m_prod[7:0];
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Scoreboard: an entry per ack, retired by the matching done pulse.
    typedef struct {
        logic        id;
        logic [31:0] prod;
        int          c;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        exp_t e;
        #3;
        if (rst) begin
            sbq.delete();
        end else begin
            if (ack0 || ack1) begin
                chk("ack_while_busy", 32'(busy), 32'd0);
                chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
                e.id   = ack1;
                e.prod = ack1 ? 32'(a1) * 32'(b1) : 32'(a0) * 32'(b0);
                e.c    = cyc;
                sbq.push_back(e);
            end
            if (done0 || done1) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: done0=%0b done1=%0b with no pending op", done0, done1);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_done_id", 32'({done1, done0}), e.id ? 32'd2 : 32'd1);
                    chk("sb_result", result, e.prod);
                    chk("sb_latency", 32'(cyc - e.c), 32'd10);
                end
            end
            if (!mul_wr_en) chk("wr_idle_zero", 32'({mul_wr_sel, mul_bus_in}), 32'd0);
            if (!mul_rd_en) chk("rd_idle_zero", 32'(mul_rd_sel), 32'd0);
        end
    end

    task automatic wait_done(input int lim, output int c);
        c = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            #2;
            if (done0 || done1) begin
                c = cyc;
                return;
            end
        end
        timeout("wait_done");
    endtask

    task automatic wait_ack(input int lim, output int id, output int c);
        id = -1;
        c  = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            #2;
            if (ack0 || ack1) begin
                id = ack1 ? 1 : 0;
                c  = cyc;
                return;
            end
        end
        timeout("wait_ack");
    endtask

    task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
        int t0, c;
        @(negedge clk);
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; end
        #2;
        chk("op_ack", 32'({ack1, ack0}), id ? 32'd2 : 32'd1);
        t0 = cyc;
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done(12, c);
        if (c >= 0) begin
            chk("op_result", result, exp);
            chk("op_latency", 32'(c - t0), 32'd10);
        end
    endtask

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c, id;
        logic [7:0] wb[4];

        vt[0] = '{1'b0, 16'h0003, 16'h0005, 32'h0000000F};
        vt[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vt[2] = '{1'b0, 16'h0000, 16'hBEEF, 32'h00000000};
        vt[3] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
        vt[4] = '{1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01};
        vt[5] = '{1'b1, 16'h0100, 16'h0100, 32'h00010000};
        vt[6] = '{1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE};
        vt[7] = '{1'b1, 16'hABCD, 16'h0001, 32'h0000ABCD};
        vt[8] = '{1'b0, 16'h1234, 16'h5678, 32'h06260060};
        wb[0] = 8'h12; wb[1] = 8'h34; wb[2] = 8'h56; wb[3] = 8'h78;

        // Reset with req0 already pending: nothing moves until rst drops.
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
        a0 = 16'h1234; b0 = 16'h5678; a1 = 16'h0000; b1 = 16'h0000;
        repeat (2) begin
            @(negedge clk);
            #2;
            chk("rst_ack", 32'({ack1, ack0}), 32'd0);
            chk("rst_done", 32'({done1, done0}), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_result", result, 32'd0);
            chk("rst_strobes", 32'({mul_wr_en, mul_wr_sel, mul_bus_in, mul_rd_en, mul_rd_sel}), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("first_idle_ack0", 32'(ack0), 32'd1);
        t0 = cyc;
        @(negedge clk);
        req0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            chk("wr_en", 32'(mul_wr_en), 32'd1);
            chk("wr_sel", 32'(mul_wr_sel), 32'(k));
            chk("wr_byte", 32'(mul_bus_in), 32'(wb[k]));
            chk("busy_mid", 32'(busy), 32'd1);
        end
        wait_done(12, c);
        if (c >= 0) begin
            chk("first_latency", 32'(c - t0), 32'd10);
            chk("first_result", result, 32'h06260060);
        end

        for (int i = 0; i < 9; i++) run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].exp);

        // Requester 1 toggles during requester 0's operation and is only served after DONE.
        @(negedge clk);
        req0 = 1'b1; a0 = 16'h0102; b0 = 16'h0304; a1 = 16'h0010; b1 = 16'h0020;
        #2;
        chk("tog_ack0", 32'(ack0), 32'd1);
        t0 = cyc;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            req0 = 1'b0;
            req1 = (k % 2 == 0);
            #2;
            chk("tog_no_ack1", 32'(ack1), 32'd0);
            if (k == 10) begin
                chk("tog_done0", 32'(done0), 32'd1);
                chk("tog_result0", result, 32'h00030A08);
            end
        end
        @(negedge clk);
        req1 = 1'b1;
        #2;
        chk("tog_ack1", 32'(ack1), 32'd1);
        chk("tog_ack1_cycle", 32'(cyc - t0), 32'd11);
        @(negedge clk);
        req1 = 1'b0;
        wait_done(12, c);
        if (c >= 0) chk("tog_result1", result, 32'h00000200);

        // Reset during RD_C2 abandons the operation.
        @(negedge clk);
        req0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222;
        #2;
        chk("abort_ack0", 32'(ack0), 32'd1);
        @(negedge clk);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        chk("abort_in_rd_c2", 32'({mul_rd_en, mul_rd_sel}), 32'b101);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_strobes", 32'({mul_wr_en, mul_wr_sel, mul_bus_in, mul_rd_en, mul_rd_sel}), 32'd0);
        chk("abort_ack_done", 32'({ack0, ack1, done0, done1}), 32'd0);
        repeat (12) begin
            @(negedge clk);
            #2;
            chk("abort_no_done", 32'({done1, done0}), 32'd0);
        end
        run_op(1'b1, 16'h1111, 16'h2222, 32'h02468642);

        // Continuous contention from reset: round-robin alternates, fixed priority never serves 1.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 16'h0007; b0 = 16'h0009; a1 = 16'h0100; b1 = 16'h00FF;
        #2;
        chk("rr_tie_ack", 32'({ack1, ack0}), 32'd1);
        chk("fp_tie_ack", 32'({fp_ack1, fp_ack0}), 32'd1);
        t0 = cyc;
        for (int k = 1; k <= 3; k++) begin
            wait_ack(15, id, c);
            if (c >= 0) begin
                chk("rr_grant_id", 32'(id), 32'(k % 2));
                chk("rr_grant_cycle", 32'(c - t0), 32'(11 * k));
                chk("fp_grant", 32'({fp_ack1, fp_ack0}), 32'd1);
            end
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done(12, c);
        if (c >= 0) chk("rr_last_result", result, 32'h0000FF00);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul16_arb_seq.md
MUL16_ARB_SEQ -- requirements
Module: mul16_arb_seq

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 The block SHALL have one clock, clk; reset is rst, synchronous, active-high.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0, req1  in  1  request from requester n; held high until ackn
- a0, b0, a1, b1  in  16  operands of requester n
- ack0, ack1  out  1  one-cycle accept pulse
- done0, done1  out  1  one-cycle result-valid pulse
- result  out  32  product of last completed operation
- busy  out  1  high whenever state != IDLE
- mul_bus_in  out  8  byte to multiplier
- mul_wr_sel  out  2  operand byte select: 00 AH, 01 AL, 10 BH, 11 BL
- mul_wr_en  out  1  multiplier operand-load enable
- mul_rd_sel  out  2  product byte select: 00 [31:24], 01 [23:16], 10 [15:8], 11 [7:0]
- mul_rd_en  out  1  multiplier output-register load enable
- mul_bus_out  in  8  registered product byte from multiplier

Function
REQ-004 The multiplier SHALL be treated as: operand byte captured on the clk edge where mul_wr_en=1; product combinational from the operand registers; mul_bus_out updated on the edge where mul_rd_en=1, visible the following cycle.
REQ-005 The FSM SHALL have states IDLE, LD_AH, LD_AL, LD_BH, LD_BL, RD_C1, RD_C2, RD_C3, RD_C4, RD_LAST, DONE, advancing one state per cycle outside IDLE.
REQ-006 In IDLE with at least one req high, the block SHALL grant one requester: ackn=1 combinationally that cycle, operands an/bn latched into internal registers and grant id stored on that edge, next state LD_AH.
REQ-007 Arbitration with RR_EN=1: single request is granted; both high -> grant the requester not granted last; after reset, requester 0 wins a tie.
REQ-008 Arbitration with RR_EN=0: both high -> requester 0 always granted.
REQ-009 LD_AH/LD_AL/LD_BH/LD_BL SHALL drive mul_wr_en=1, mul_wr_sel 00/01/10/11, mul_bus_in = latched A[15:8]/A[7:0]/B[15:8]/B[7:0].
REQ-010 RD_C1..RD_C4 SHALL drive mul_rd_en=1, mul_rd_sel 00/01/10/11.
REQ-011 RD_C2, RD_C3, RD_C4, RD_LAST SHALL capture mul_bus_out into result[31:24], [23:16], [15:8], [7:0] respectively on the edge leaving that state.
REQ-012 In DONE, donen for the granted requester SHALL be 1 for exactly one cycle with result holding the full product; next state IDLE.
REQ-013 Latency: ack cycle = cycle 0; done asserted in cycle 10; minimum spacing between consecutive acks 11 cycles.
REQ-014 mul_wr_en and mul_rd_en SHALL be 0 in all states other than those in REQ-009/REQ-010; mul_bus_in, mul_wr_sel and mul_rd_sel SHALL be 0 when their enable is 0.
REQ-015 result SHALL hold its value between completions; it updates byte-wise during RD states, so it is valid only while donen=1 and afterwards until the next grant.
REQ-016 req changes outside IDLE SHALL be ignored; no ack SHALL be issued while busy=1.
REQ-017 Operands SHALL be unsigned; result = a*b exact in 32 bits (max 0xFFFE0001).

Reset
REQ-018 rst=1 at any edge, including mid-operation, SHALL force IDLE; ack/done/busy/enables/selects/mul_bus_in = 0, result = 0, last-grant pointer = requester 1 (so requester 0 wins a tie).
REQ-019 An operation interrupted by reset SHALL produce no done; a req held through reset SHALL be granted in the first IDLE cycle after rst deasserts.

Verification
REQ-020 req0, a0=0x1234, b0=0x5678 -> ack0 cycle 0, wr bytes 12,34,56,78 cycles 1-4, done0 cycle 10, result=0x06260060.
REQ-021 req0 and req1 high simultaneously after reset, RR_EN=1 -> req0 granted first, req1 acked in cycle 11; second pair -> req1 granted first.
REQ-022 RR_EN=0, both requesters held high for 3 operations -> only requester 0 is ever acked.
REQ-023 a1=0xFFFF, b1=0xFFFF -> result=0xFFFE0001; a0=0x0000, b0=0xBEEF -> result=0x00000000.
REQ-024 rst asserted in RD_C2 -> next cycle IDLE, all outputs 0, no done pulse; subsequent request completes with correct product.
REQ-025 req toggled by requester 1 while busy serving requester 0 -> no ack1 until the cycle after DONE.
